multiply_seq: RTL
=================

# multiply_seq

Parametrised iterative shift-add multiplier: the next-generation multiply unit for the datapath experiments. It multiplies two WIDTH-bit operands, signed or unsigned as selected per operation, into a 2·WIDTH-bit product. It adds a synchronous reset, an explicit busy/done handshake, operand capture at start, early termination on a zero multiplier, and a held result register. It sits beside the ALU and is started by the control unit with a one-cycle request.

## Interface
- WIDTH, 32: operand width in bits; legal values are 4..64.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mult_begin  input  1  start request; sampled only in IDLE.
- mult_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with mult_begin.
- mult_op1  input  WIDTH  multiplicand; sampled at the accept edge.
- mult_op2  input  WIDTH  multiplier; sampled at the accept edge.
- busy  output  1  high while an operation is in flight (BUSY and DONE states).
- product  output  2·WIDTH  result register; holds its value until the next completion.
- mult_end  output  1  one-cycle completion pulse; product is valid in the same cycle.

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: iterating.
  - DONE: one cycle, signalling completion.
- IDLE -> BUSY on an edge where mult_begin=1 (the accept edge). At that edge:
  - Capture the sign flag s = mult_signed & (op1[W-1] ^ op2[W-1]).
  - Load mcand = {W zeros, |op1|} (2W bits) and mplier = |op2| (W bits).
  - Clear acc (2W bits).
  - |x| = ~x+1 when mult_signed and x[W-1]=1; otherwise |x| = x. Both are treated as W-bit unsigned, so |-2^(W-1)| = 2^(W-1).
- BUSY, when mplier != 0, performs one step per edge:
  - acc += mcand if mplier[0]=1.
  - mcand <<= 1.
  - mplier >>= 1 (zero fill).
- BUSY with mplier == 0 -> DONE. At that edge product <= s ? (~acc+1) : acc, truncated to 2W bits, and mult_end goes high.
- DONE -> IDLE unconditionally. mult_end drops on that edge.
- mult_begin is ignored in BUSY and DONE. Requests are not queued.
- Operand or mode changes after the accept edge have no effect.
- A product of zero is never negated: a signed zero result stays all-zeros.

## Timing
- Reset values: busy=0, mult_end=0, product=0, state=IDLE.
- Internal registers mcand, mplier, acc and s are don't-care after reset.
- Reset asserted mid-operation aborts the operation at that edge. The partial result is discarded, product is cleared, and no mult_end is issued.
- Reset has priority over mult_begin.
- Let p = bit index of the most significant 1 in |op2|, plus 1. p = 0 when op2 = 0.
- Number the accept edge E0.
  - Steps occur at edges E1..Ep.
  - The product write and mult_end rise occur at E(p+1).
  - busy is high from E0 to E(p+2).
- mult_end is high for exactly one cycle, beginning p+1 cycles after the accept edge. Minimum is 1 (op2=0); maximum is WIDTH+1.
- busy=1 for p+2 cycles. The earliest next accept is at E(p+2).
- product changes only at a completion edge or on reset. It is stable across IDLE.

## Test plan
- WIDTH=32, rst mid-run: start 7×9 unsigned, assert rst at E2 -> busy=0, product=0 at the next cycle, and no mult_end pulse follows.
- WIDTH=32, unsigned, 0xFFFFFFFF × 0xFFFFFFFF -> product=0xFFFFFFFE00000001, mult_end exactly 33 cycles after the accept edge, busy high for 34 cycles.
- WIDTH=32, signed, -3 × 5 -> product=0xFFFFFFFFFFFFFFF1, mult_end 4 cycles after accept. Then signed 0x80000000 × 0x80000000 -> 0x4000000000000000.
- WIDTH=8, signed -128 × 0 -> product=0x0000, mult_end 1 cycle after accept. Then unsigned 0x80 × 0x02 -> 0x0100, mult_end 3 cycles after accept.
- WIDTH=16, hold mult_begin high continuously with operands changing every cycle -> each accept occurs only in IDLE, every product matches the operands present at its accept edge, and mult_end pulses never exceed one cycle.

Source files
------------

// File: rtl/multiply_seq.sv
// Iterative shift-add multiplier, signed or unsigned per operation.
// Produces a 2*WIDTH-bit product with a busy/done handshake and a held result register.
module multiply_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mult_begin,
    input  logic                 mult_signed,
    input  logic [WIDTH-1:0]     mult_op1,
    input  logic [WIDTH-1:0]     mult_op2,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product,
    output logic                 mult_end
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     mplier_r;
    logic                 sign_r;
    logic                 mplier_zero_s;
    logic [2*WIDTH-1:0]   result_s;

    // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1) as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        if (sgn && x[WIDTH-1]) begin
            magnitude = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = x;
        end
    endfunction

    assign mplier_zero_s = (mplier_r == {WIDTH{1'b0}});

    // Final sign correction; negating zero yields zero so a signed zero stays clean.
    always_comb begin
        result_s = acc_r;
        if (sign_r) begin
            result_s = ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result_s = acc_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mult_begin) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mplier_zero_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered handshake outputs and the held product.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            mult_end <= 1'b0;
            product  <= {(2*WIDTH){1'b0}};
        end else begin
            busy     <= (state_next_s != ST_IDLE);
            mult_end <= (state_next_s == ST_DONE);
            if ((state_r == ST_BUSY) && mplier_zero_s) begin
                product <= result_s;
            end else begin
                product <= product;
            end
        end
    end

    // Operand capture at accept, then one shift-add step per cycle until the multiplier empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= {(2*WIDTH){1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            sign_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mult_begin) begin
                        sign_r   <= mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
                        mcand_r  <= {{WIDTH{1'b0}}, magnitude(mult_op1, mult_signed)};
                        mplier_r <= magnitude(mult_op2, mult_signed);
                        acc_r    <= {(2*WIDTH){1'b0}};
                    end else begin
                        mcand_r  <= mcand_r;
                    end
                end
                ST_BUSY: begin
                    if (!mplier_zero_s) begin
                        if (mplier_r[0]) begin
                            acc_r <= acc_r + mcand_r;
                        end else begin
                            acc_r <= acc_r;
                        end
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                    end else begin
                        mcand_r  <= mcand_r;
                    end
                end
                default: begin
                    mcand_r <= mcand_r;
                end
            endcase
        end
    end

endmodule
